// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | mem_arbiter: IF/MEM arbiter for one single-port memory, one outstanding  |
// | transaction, data priority with fetch starvation guard. Rev 1.0          |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_if_req,
   input  logic [ADDR_W-1:0]     i_if_addr,
   input  logic                  i_if_flush,
   output logic                  o_if_gnt,
   output logic                  o_if_rvalid,
   output logic [DATA_W-1:0]     o_if_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [DATA_W/8-1:0]   i_d_be,
   input  logic [ADDR_W-1:0]     i_d_addr,
   input  logic [DATA_W-1:0]     i_d_wdata,
   output logic                  o_d_gnt,
   output logic                  o_d_rvalid,
   output logic [DATA_W-1:0]     o_d_rdata,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [DATA_W/8-1:0]   o_mem_be,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_wdata,
   input  logic                  i_mem_gnt,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_W-1:0]     i_mem_rdata,
   output logic                  o_busy
);

   localparam int                c_BE_W  = DATA_W / 8;
   localparam int                c_CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RSP = 2'd2
   } state_t;

   state_t               r_state, w_state;
   logic                 r_owner_if, w_owner_if;
   logic [c_CNT_W-1:0]   r_starve, w_starve;
   logic                 r_flush_pend, w_flush_pend;
   logic                 r_mem_req, w_mem_req;
   logic                 r_mem_we, w_mem_we;
   logic [c_BE_W-1:0]    r_mem_be, w_mem_be;
   logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr;
   logic [DATA_W-1:0]    r_mem_wdata, w_mem_wdata;
   logic                 r_if_gnt, w_if_gnt;
   logic                 r_d_gnt, w_d_gnt;
   logic                 r_if_rvalid, w_if_rvalid;
   logic                 r_d_rvalid, w_d_rvalid;
   logic [DATA_W-1:0]    r_if_rdata, w_if_rdata;
   logic [DATA_W-1:0]    r_d_rdata, w_d_rdata;
   logic                 w_pick_if;
   logic                 w_complete;

   assign w_pick_if = !i_d_req || (i_if_req && (r_starve == c_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state;
   end

   always_comb begin
      w_state      = r_state;
      w_owner_if   = r_owner_if;
      w_starve     = r_starve;
      w_flush_pend = r_flush_pend;
      w_mem_req    = r_mem_req;
      w_mem_we     = r_mem_we;
      w_mem_be     = r_mem_be;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_if_gnt     = 1'b0;
      w_d_gnt      = 1'b0;
      w_if_rvalid  = 1'b0;
      w_d_rvalid   = 1'b0;
      w_if_rdata   = r_if_rdata;
      w_d_rdata    = r_d_rdata;
      w_complete   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_if_req || i_d_req) begin
               if (w_pick_if) begin
                  w_mem_we    = 1'b0;
                  w_mem_be    = '1;
                  w_mem_addr  = i_if_addr;
                  w_mem_wdata = '0;
                  w_if_gnt    = 1'b1;
               end else begin
                  w_mem_we    = i_d_we;
                  w_mem_be    = i_d_be;
                  w_mem_addr  = i_d_addr;
                  w_mem_wdata = i_d_wdata;
                  w_d_gnt     = 1'b1;
               end
               w_owner_if = w_pick_if;
               w_mem_req  = 1'b1;
               w_state    = S_ISSUE;
               // Count only data grants that actually bypass a waiting fetch
               if (!w_pick_if && i_if_req)
                  w_starve = (r_starve == c_LIMIT) ? r_starve : r_starve + 1'b1;
               else
                  w_starve = '0;
            end
         end
         S_ISSUE: begin
            if (i_mem_gnt) begin
               w_mem_req = 1'b0;
               if (i_mem_rvalid) w_complete = 1'b1;
               else              w_state    = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (i_mem_rvalid) w_complete = 1'b1;
         end
         default: w_state = S_IDLE;
      endcase

      if ((r_state != S_IDLE) && r_owner_if && i_if_flush)
         w_flush_pend = 1'b1;

      // A flush arriving in the completing cycle still suppresses the fetch
      if (w_complete) begin
         w_state      = S_IDLE;
         w_flush_pend = 1'b0;
         if (r_owner_if) begin
            if (!(r_flush_pend || i_if_flush)) begin
               w_if_rvalid = 1'b1;
               w_if_rdata  = i_mem_rdata;
            end
         end else begin
            w_d_rvalid = 1'b1;
            w_d_rdata  = r_mem_we ? '0 : i_mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner_if   <= 1'b0;
         r_starve     <= '0;
         r_flush_pend <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_be     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_gnt     <= 1'b0;
         r_d_gnt      <= 1'b0;
         r_if_rvalid  <= 1'b0;
         r_d_rvalid   <= 1'b0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
      end else begin
         r_owner_if   <= w_owner_if;
         r_starve     <= w_starve;
         r_flush_pend <= w_flush_pend;
         r_mem_req    <= w_mem_req;
         r_mem_we     <= w_mem_we;
         r_mem_be     <= w_mem_be;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_if_gnt     <= w_if_gnt;
         r_d_gnt      <= w_d_gnt;
         r_if_rvalid  <= w_if_rvalid;
         r_d_rvalid   <= w_d_rvalid;
         r_if_rdata   <= w_if_rdata;
         r_d_rdata    <= w_d_rdata;
      end
   end

   assign o_if_gnt    = r_if_gnt;
   assign o_if_rvalid = r_if_rvalid;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_gnt     = r_d_gnt;
   assign o_d_rvalid  = r_d_rvalid;
   assign o_d_rdata   = r_d_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_be    = r_mem_be;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: vector table + scoreboard bench for mem_arbiter. Rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_mem_req, o_mem_we, o_busy;
   logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
      .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic is_if; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } gnt_t;
   typedef struct { logic is_if; logic [31:0] data; } rsp_t;
   typedef struct {
      logic ifr; logic dr; logic we; logic [3:0] be;
      logic [31:0] ia; logic [31:0] da; logic [31:0] wd; logic [31:0] rdata;
      int gw; int rw;
      logic exp_first_if; logic [31:0] exp_if_rdata; logic [31:0] exp_d_rdata;
   } vec_t;

   gnt_t gq[$];
   rsp_t rq[$];
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_if_hold = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_gnt(input logic is_if, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd);
      gnt_t g;
      g.is_if = is_if; g.addr = a;
      g.we = is_if ? 1'b0 : we; g.be = is_if ? 4'hF : be; g.wdata = is_if ? 32'h0 : wd;
      gq.push_back(g);
   endtask

   task automatic push_rsp(input logic is_if, input logic [31:0] d);
      rsp_t r;
      r.is_if = is_if; r.data = d;
      rq.push_back(r);
      if (is_if) exp_if_hold = d;
   endtask

   // Memory model: grants after gnt_wait stall cycles, answers rsp_wait cycles later
   int gnt_wait = 0, rsp_wait = 1;
   logic [31:0] mem_data = '0;
   int m_phase = 0, m_cnt = 0, cyc = 0, rsp_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (m_phase == 0) begin
         if (o_mem_req) begin
            if (m_cnt >= gnt_wait) begin
               mem_gnt = 1'b1;
               m_cnt = 0;
               if (rsp_wait == 0) begin
                  mem_rvalid = 1'b1; mem_rdata = mem_data; rsp_cyc = cyc;
               end else m_phase = 1;
            end else m_cnt++;
         end
      end else begin
         m_cnt++;
         if (m_cnt >= rsp_wait) begin
            mem_rvalid = 1'b1; mem_rdata = mem_data; rsp_cyc = cyc;
            m_phase = 0; m_cnt = 0;
         end
      end
   end

   // Monitor: grants and responses are popped from the scoreboard queues
   logic        p_req = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [3:0]  p_be = '0;

   always @(negedge clk) begin
      gnt_t g;
      rsp_t r;
      if (!rst_n) p_req = 1'b0;
      else begin
         if (o_mem_req && p_req) begin
            chk("stall_addr", o_mem_addr, p_addr);
            chk("stall_wdata", o_mem_wdata, p_wdata);
            chk("stall_be_we", 32'({o_mem_be, o_mem_we}), 32'({p_be, p_we}));
         end
         p_req = o_mem_req; p_addr = o_mem_addr; p_wdata = o_mem_wdata;
         p_be = o_mem_be; p_we = o_mem_we;

         if (o_if_gnt || o_d_gnt) begin
            chk("gnt_exclusive", 32'(o_if_gnt & o_d_gnt), 32'h0);
            if (gq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_gnt: if_gnt=%0b d_gnt=%0b, expected no grant", o_if_gnt, o_d_gnt);
            end else begin
               g = gq.pop_front();
               chk("gnt_kind_if", 32'(o_if_gnt), 32'(g.is_if));
               chk("gnt_mem_req", 32'(o_mem_req), 32'h1);
               chk("gnt_mem_addr", o_mem_addr, g.addr);
               chk("gnt_mem_we_be", 32'({o_mem_we, o_mem_be}), 32'({g.we, g.be}));
               chk("gnt_mem_wdata", o_mem_wdata, g.wdata);
            end
         end

         if (o_if_rvalid || o_d_rvalid) begin
            chk("rvalid_exclusive", 32'(o_if_rvalid & o_d_rvalid), 32'h0);
            chk("rvalid_latency", 32'(cyc), 32'(rsp_cyc + 1));
            chk("busy_at_rvalid", 32'(o_busy), 32'h0);
            if (rq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b, expected none", o_if_rvalid, o_d_rvalid);
            end else begin
               r = rq.pop_front();
               chk("rsp_kind_if", 32'(o_if_rvalid), 32'(r.is_if));
               chk("rsp_rdata", r.is_if ? o_if_rdata : o_d_rdata, r.data);
            end
         end
      end
   end

   task automatic run_until_idle(input string name);
      int n = 0;
      do begin
         if (o_if_gnt) if_req = 1'b0;
         if (o_d_gnt)  d_req  = 1'b0;
         @(negedge clk);
         n++;
      end while ((if_req || d_req || o_busy || gq.size() != 0 || rq.size() != 0) && n < 200);
      if (n >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
      end
      @(negedge clk);
   endtask

   // Single transaction with an if_flush pulse while waiting for the response
   task automatic txn_flush(input logic is_if, input logic [31:0] a, input logic [31:0] rd,
                            input logic exp_rsp);
      gnt_wait = 0; rsp_wait = 3; mem_data = rd;
      push_gnt(is_if, a, 1'b0, 4'hF, 32'h0);
      if (exp_rsp) push_rsp(is_if, rd);
      if (is_if) begin if_addr = a; if_req = 1'b1; end
      else begin d_addr = a; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1; end
      @(negedge clk);
      chk("flush_gnt", 32'({o_if_gnt, o_d_gnt}), is_if ? 32'h2 : 32'h1);
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("flush_in_wait_rsp", 32'({o_busy, o_mem_req}), 32'h2);
      if_flush = 1'b1;
      @(negedge clk);
      if_flush = 1'b0;
      run_until_idle("flush");
   endtask

   vec_t vt[6];

   initial begin
      vt[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0, 32'h0010_0093, 0, 2,
                1'b1, 32'h0010_0093, 32'h0};
      vt[1] = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0104, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1,
                1'b0, 32'h0BAD_F00D, 32'h0};
      vt[2] = '{1'b0, 1'b1, 1'b0, 4'h3, 32'h0, 32'h0000_3000, 32'h1111_2222, 32'hCAFE_0001, 5, 1,
                1'b0, 32'h0, 32'hCAFE_0001};
      vt[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'h0, 32'h0000_0013, 0, 0,
                1'b1, 32'h0000_0013, 32'h0};
      vt[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0204, 32'h0000_3004, 32'h0, 32'h8765_4321, 2, 0,
                1'b0, 32'h8765_4321, 32'h8765_4321};
      vt[5] = '{1'b0, 1'b1, 1'b1, 4'h5, 32'h0, 32'h0000_3008, 32'h0102_0304, 32'hFFFF_FFFF, 1, 3,
                1'b0, 32'h0, 32'h0};

      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(o_busy), 32'h0);
      chk("reset_mem_req", 32'(o_mem_req), 32'h0);
      chk("reset_pulses", 32'({o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid}), 32'h0);
      chk("reset_if_rdata", o_if_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         gnt_wait = vt[i].gw; rsp_wait = vt[i].rw; mem_data = vt[i].rdata;
         if_addr = vt[i].ia; d_addr = vt[i].da; d_we = vt[i].we; d_be = vt[i].be; d_wdata = vt[i].wd;
         if (vt[i].dr) begin
            push_gnt(1'b0, vt[i].da, vt[i].we, vt[i].be, vt[i].wd);
            push_rsp(1'b0, vt[i].exp_d_rdata);
         end
         if (vt[i].ifr) begin
            push_gnt(1'b1, vt[i].ia, 1'b0, 4'hF, 32'h0);
            push_rsp(1'b1, vt[i].exp_if_rdata);
         end
         if_req = vt[i].ifr; d_req = vt[i].dr;
         @(negedge clk);
         chk("first_gnt", 32'({o_if_gnt, o_d_gnt}), vt[i].exp_first_if ? 32'h2 : 32'h1);
         run_until_idle("vector");
      end

      // Starvation guard: both requesters held high continuously
      begin
         int ng = 0, n = 0;
         gnt_wait = 0; rsp_wait = 0; mem_data = 32'h5555_AAAA;
         if_addr = 32'h0000_0300; d_addr = 32'h0000_0400; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
         for (int k = 0; k < 10; k++) begin
            push_gnt(k % 5 == 4, (k % 5 == 4) ? 32'h0000_0300 : 32'h0000_0400, 1'b0, 4'hF, 32'h0);
            push_rsp(k % 5 == 4, 32'h5555_AAAA);
         end
         if_req = 1'b1; d_req = 1'b1;
         while (ng < 10 && n < 300) begin
            @(negedge clk);
            n++;
            if (o_if_gnt || o_d_gnt) ng++;
         end
         if_req = 1'b0; d_req = 1'b0;
         chk("starve_grant_count", 32'(ng), 32'd10);
         run_until_idle("starve");
      end

      // Flushed fetch, then a data read that ignores the flush, then a normal fetch
      txn_flush(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0);
      chk("flush_if_rdata_hold", o_if_rdata, exp_if_hold);
      txn_flush(1'b0, 32'h0000_0500, 32'h0A0B_0C0D, 1'b1);
      gnt_wait = 0; rsp_wait = 1; mem_data = 32'h0000_0013;
      push_gnt(1'b1, 32'h0000_0080, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b1, 32'h0000_0013);
      if_addr = 32'h0000_0080; if_req = 1'b1;
      run_until_idle("post_flush");

      // Reset in WAIT_RSP; the late memory response must be dropped
      gnt_wait = 0; rsp_wait = 6; mem_data = 32'h0000_0077;
      push_gnt(1'b0, 32'h0000_0600, 1'b0, 4'hF, 32'h0);
      d_addr = 32'h0000_0600; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
      @(negedge clk);
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_wait_rsp", 32'({o_busy, o_mem_req}), 32'h2);
      rst_n = 1'b0;
      #1;
      chk("rst_async_busy_req", 32'({o_busy, o_mem_req, o_mem_we}), 32'h0);
      chk("rst_async_mem_addr", o_mem_addr, 32'h0);
      chk("rst_async_d_rdata", o_d_rdata, 32'h0);
      chk("rst_async_if_rdata", o_if_rdata, 32'h0);
      exp_if_hold = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_idle", 32'(o_busy), 32'h0);
      gnt_wait = 0; rsp_wait = 1; mem_data = 32'h0000_00AB;
      push_gnt(1'b1, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
      push_rsp(1'b1, 32'h0000_00AB);
      if_addr = 32'h0000_0700; if_req = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", 32'({o_if_gnt, o_d_gnt}), 32'h2);
      run_until_idle("post_rst");

      chk("gnt_queue_empty", 32'(gq.size()), 32'h0);
      chk("rsp_queue_empty", 32'(rq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
